// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache/dcache refill reads and a one-entry dcache write buffer.
// Define ARB_RR_EN for round-robin read arbitration; otherwise dcache wins every tie.
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         resetn,
    // icache read
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    output logic [31:0]  i_ret_data,
    // dcache read
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  d_ret_data,
    // dcache writeback
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    // memory side
    output logic         m_rd_req,
    output logic [2:0]   m_rd_type,
    output logic [31:0]  m_rd_addr,
    input  logic         m_rd_rdy,
    input  logic         m_ret_valid,
    input  logic         m_ret_last,
    input  logic [31:0]  m_ret_data,
    output logic         m_wr_req,
    output logic [2:0]   m_wr_type,
    output logic [31:0]  m_wr_addr,
    output logic [3:0]   m_wr_wstrb,
    output logic [127:0] m_wr_data,
    input  logic         m_wr_rdy
);
    typedef enum logic [1:0] {RIdle, RReq, RData} r_state_e;
    typedef enum logic {WIdle, WBusy} w_state_e;

    r_state_e     r_state_q, r_state_d;
    w_state_e     w_state_q, w_state_d;
    logic         gnt_d_q, gnt_d_d;
    logic [2:0]   rd_type_q, rd_type_d;
    logic [31:0]  rd_addr_q, rd_addr_d;
    logic [2:0]   wr_type_q, wr_type_d;
    logic [31:0]  wr_addr_q, wr_addr_d;
    logic [3:0]   wr_wstrb_q, wr_wstrb_d;
    logic [127:0] wr_data_q, wr_data_d;
    logic         any_rd, win_d, conflict;

    assign any_rd = i_rd_req | d_rd_req;

`ifdef ARB_RR_EN
    // Remembers whether dcache took the previous grant; cleared so the first tie goes to dcache.
    logic last_d_q;
    assign win_d = d_rd_req & (~i_rd_req | ~last_d_q);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_d_q <= 1'b0;
        end else if (r_state_q == RIdle && any_rd) begin
            last_d_q <= win_d;
        end
    end
`else
    assign win_d = d_rd_req;
`endif

    // A read of the line still sitting in the write buffer must wait for the write to drain.
    assign conflict = (w_state_q == WBusy) && (rd_addr_q[31:4] == wr_addr_q[31:4]);

    always_comb begin
        r_state_d   = r_state_q;
        w_state_d   = w_state_q;
        gnt_d_d     = gnt_d_q;
        rd_type_d   = rd_type_q;
        rd_addr_d   = rd_addr_q;
        wr_type_d   = wr_type_q;
        wr_addr_d   = wr_addr_q;
        wr_wstrb_d  = wr_wstrb_q;
        wr_data_d   = wr_data_q;
        i_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_ret_data  = '0;
        d_rd_rdy    = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        d_ret_data  = '0;
        d_wr_rdy    = 1'b1;
        m_rd_req    = 1'b0;
        m_rd_type   = '0;
        m_rd_addr   = '0;
        m_wr_req    = 1'b0;
        m_wr_type   = '0;
        m_wr_addr   = '0;
        m_wr_wstrb  = '0;
        m_wr_data   = '0;

        // Outputs stay quiet while resetn is low, even before the state registers clear.
        if (resetn) begin
            unique case (r_state_q)
                RIdle: begin
                    if (any_rd) begin
                        gnt_d_d   = win_d;
                        rd_type_d = win_d ? d_rd_type : i_rd_type;
                        rd_addr_d = win_d ? d_rd_addr : i_rd_addr;
                        i_rd_rdy  = ~win_d;
                        d_rd_rdy  = win_d;
                        r_state_d = RReq;
                    end
                end
                RReq: begin
                    if (!conflict) begin
                        m_rd_req  = 1'b1;
                        m_rd_type = rd_type_q;
                        m_rd_addr = rd_addr_q;
                        if (m_rd_rdy) r_state_d = RData;
                    end
                end
                RData: begin
                    if (gnt_d_q) begin
                        d_ret_valid = m_ret_valid;
                        d_ret_last  = m_ret_valid & m_ret_last;
                        d_ret_data  = m_ret_valid ? m_ret_data : '0;
                    end else begin
                        i_ret_valid = m_ret_valid;
                        i_ret_last  = m_ret_valid & m_ret_last;
                        i_ret_data  = m_ret_valid ? m_ret_data : '0;
                    end
                    if (m_ret_valid && m_ret_last) r_state_d = RIdle;
                end
                default: r_state_d = RIdle;
            endcase

            unique case (w_state_q)
                WIdle: begin
                    if (d_wr_req) begin
                        wr_type_d  = d_wr_type;
                        wr_addr_d  = d_wr_addr;
                        wr_wstrb_d = d_wr_wstrb;
                        wr_data_d  = d_wr_data;
                        w_state_d  = WBusy;
                    end
                end
                WBusy: begin
                    d_wr_rdy   = 1'b0;
                    m_wr_req   = 1'b1;
                    m_wr_type  = wr_type_q;
                    m_wr_addr  = wr_addr_q;
                    m_wr_wstrb = wr_wstrb_q;
                    m_wr_data  = wr_data_q;
                    if (m_wr_rdy) w_state_d = WIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q  <= RIdle;
            w_state_q  <= WIdle;
            gnt_d_q    <= 1'b0;
            rd_type_q  <= '0;
            rd_addr_q  <= '0;
            wr_type_q  <= '0;
            wr_addr_q  <= '0;
            wr_wstrb_q <= '0;
            wr_data_q  <= '0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            gnt_d_q    <= gnt_d_d;
            rd_type_q  <= rd_type_d;
            rd_addr_q  <= rd_addr_d;
            wr_type_q  <= wr_type_d;
            wr_addr_q  <= wr_addr_d;
            wr_wstrb_q <= wr_wstrb_d;
            wr_data_q  <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-plus-random bench for cache_mem_arbiter; expectations come from a transaction-level
// model of the grant policy, write-buffer line hazard and beat routing.
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         i_rd_req, d_rd_req, d_wr_req;
    logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
    logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         i_rd_rdy, i_ret_valid, i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
    logic [31:0]  d_ret_data;
    logic         m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last, m_wr_req, m_wr_rdy;
    logic [2:0]   m_rd_type, m_wr_type;
    logic [31:0]  m_rd_addr, m_wr_addr, m_ret_data;
    logic [3:0]   m_wr_wstrb;
    logic [127:0] m_wr_data;

    cache_mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
        .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy)
    );

    int checks = 0;
    int errors = 0;
    bit last_d;  // model: previous read grant went to dcache
    logic [31:0]  w_addr_m;
    logic [2:0]   w_type_m;
    logic [3:0]   w_strb_m;
    logic [127:0] w_data_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic outs_any();
        return |{i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data, d_rd_rdy, d_ret_valid, d_ret_last,
                 d_ret_data, m_rd_req, m_rd_type, m_rd_addr, m_wr_req, m_wr_type, m_wr_addr,
                 m_wr_wstrb, m_wr_data};
    endfunction

    function automatic bit pick_d(input bit ri, input bit rd);
        if (ri && rd) begin
`ifdef ARB_RR_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return rd;
    endfunction

    task automatic grant(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                         output bit wd, output logic [31:0] ea, output logic [2:0] et);
        logic [2:0] it, dt;
        it = 3'($urandom_range(0, 7));
        dt = 3'($urandom_range(0, 7));
        i_rd_req = ri; i_rd_addr = ia; i_rd_type = it;
        d_rd_req = rd; d_rd_addr = da; d_rd_type = dt;
        wd = pick_d(ri, rd);
        ea = wd ? da : ia;
        et = wd ? dt : it;
        @(negedge clk);
        chk("rd_rdy_winner", wd ? d_rd_rdy : i_rd_rdy, 1);
        chk("rd_rdy_loser", wd ? i_rd_rdy : d_rd_rdy, 0);
        last_d = wd;
        tick();
        if (wd) d_rd_req = 1'b0; else i_rd_req = 1'b0;
    endtask

    // Stray return beats are thrown at the arbiter while the request is outstanding.
    task automatic addr_phase(input logic [31:0] ea, input logic [2:0] et, input int lat);
        for (int c = 0; c <= lat; c++) begin
            m_rd_rdy    = (c == lat);
            m_ret_valid = 1'($urandom_range(0, 1));
            m_ret_last  = 1'($urandom_range(0, 1));
            m_ret_data  = $urandom();
            @(negedge clk);
            chk("m_rd_req", m_rd_req, 1);
            chk("m_rd_addr", m_rd_addr, ea);
            chk("m_rd_type", m_rd_type, et);
            chk("quiet_in_req", {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid}, 0);
            tick();
        end
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0;
    endtask

    task automatic data_phase(input bit wd, input int nbeats, input int nsend);
        for (int b = 0; b < nsend; b++) begin
            logic [31:0] w;
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                m_ret_valid = 1'b0;
                m_ret_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("ret_gap", {i_ret_valid, d_ret_valid}, 0);
                tick();
            end
            w = $urandom();
            m_ret_valid = 1'b1;
            m_ret_last  = (b == nbeats - 1);
            m_ret_data  = w;
            @(negedge clk);
            chk("ret_valid_owner", wd ? d_ret_valid : i_ret_valid, 1);
            chk("ret_data_owner", wd ? d_ret_data : i_ret_data, w);
            chk("ret_last_owner", wd ? d_ret_last : i_ret_last, b == nbeats - 1);
            chk("ret_other", wd ? {i_ret_valid, i_ret_last} : {d_ret_valid, d_ret_last}, 0);
            chk("no_grant_in_data", {i_rd_rdy, d_rd_rdy}, 0);
            tick();
        end
        m_ret_valid = 1'b0; m_ret_last = 1'b0;
    endtask

    task automatic do_read(input bit ri, input bit rd, input logic [31:0] ia,
                           input logic [31:0] da, input int lat, input int nbeats);
        bit wd;
        logic [31:0] ea;
        logic [2:0] et;
        grant(ri, rd, ia, da, wd, ea, et);
        addr_phase(ea, et, lat);
        data_phase(wd, nbeats, nbeats);
    endtask

    task automatic wr_drive(input logic [31:0] a);
        w_addr_m = a;
        w_type_m = 3'($urandom_range(0, 7));
        w_strb_m = 4'($urandom_range(0, 15));
        w_data_m = {$urandom(), $urandom(), $urandom(), $urandom()};
        d_wr_req = 1'b1; d_wr_addr = a; d_wr_type = w_type_m;
        d_wr_wstrb = w_strb_m; d_wr_data = w_data_m;
    endtask

    task automatic wr_check_busy();
        chk("m_wr_req", m_wr_req, 1);
        chk("m_wr_addr", m_wr_addr, w_addr_m);
        chk("m_wr_type", m_wr_type, w_type_m);
        chk("m_wr_wstrb", m_wr_wstrb, w_strb_m);
        chk("m_wr_data", m_wr_data, w_data_m);
        chk("d_wr_rdy_busy", d_wr_rdy, 0);
    endtask

    initial begin
        bit wd;
        logic [31:0] ea;
        logic [2:0] et;
        logic [31:0] wa, ra;
        bit same;

        resetn = 1'b0;
        {i_rd_req, d_rd_req, d_wr_req, m_rd_rdy, m_ret_valid, m_ret_last, m_wr_rdy} = '0;
        {i_rd_type, d_rd_type, d_wr_type, d_wr_wstrb} = '0;
        {i_rd_addr, d_rd_addr, d_wr_addr, m_ret_data} = '0;
        d_wr_data = '0;
        last_d = 1'b0;

        // Requests during reset must not be granted.
        tick();
        i_rd_req = 1'b1; d_rd_req = 1'b1; d_wr_req = 1'b1;
        @(negedge clk);
        chk("reset_outs", outs_any(), 0);
        chk("reset_wr_rdy", d_wr_rdy, 1);
        tick();
        {i_rd_req, d_rd_req, d_wr_req} = '0;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", outs_any(), 0);
        chk("post_reset_wr_rdy", d_wr_rdy, 1);
        tick();

        // Ties from reset, loser stays pending and is served next.
        do_read(1, 1, $urandom(), $urandom(), 1, 4);
        do_read(1, 1, $urandom(), $urandom(), 0, 2);
        do_read(last_d, !last_d, $urandom(), $urandom(), 1, 3);

        // Lone icache refill of 0x1C000000.
        do_read(1, 0, 32'h1C00_0000, 32'h0, 2, 4);

        // Stray beat while idle is dropped and the read FSM stays idle.
        m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = $urandom();
        @(negedge clk);
        chk("stray_idle", {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
        tick();
        m_ret_valid = 1'b0; m_ret_last = 1'b0;
        do_read(0, 1, 32'h0, $urandom(), 0, 4);

        // Read-after-write hazard on the buffered line vs. an unrelated line.
        for (int t = 0; t < 3; t++) begin
            wa = (t == 0) ? 32'h0000_1230 : $urandom();
            if (t == 0) ra = 32'h0000_1238;
            else if (t == 1) ra = {wa[31:4], 4'($urandom_range(0, 15))};
            else ra = wa ^ 32'h0000_0100;
            same = (ra[31:4] == wa[31:4]);
            wr_drive(wa);
            m_wr_rdy = 1'b0;
            @(negedge clk);
            chk("wr_accept", d_wr_rdy, 1);
            tick();
            d_wr_req = 1'b0;
            grant(0, 1, 32'h0, ra, wd, ea, et);
            repeat (4) begin
                @(negedge clk);
                chk("raw_hold", m_rd_req, !same);
                wr_check_busy();
                tick();
            end
            m_wr_rdy = 1'b1;
            @(negedge clk);
            chk("raw_hold_drain", m_rd_req, !same);
            wr_check_busy();
            tick();
            m_wr_rdy = 1'b0;
            @(negedge clk);
            chk("wr_drained", {m_wr_req, d_wr_rdy}, 2'b01);
            chk("rd_after_drain", m_rd_req, 1);
            tick();
            addr_phase(ea, et, $urandom_range(0, 2));
            data_phase(1, 4, 4);
        end

        // Write and read accepted in the same cycle and issued concurrently.
        for (int t = 0; t < 2; t++) begin
            ra = (t == 0) ? 32'h0000_3000 : $urandom();
            wa = (t == 0) ? 32'h0000_2000 : (ra ^ 32'h0000_0010);
            wr_drive(wa);
            m_wr_rdy = 1'b0;
            grant(t == 0, t == 1, ra, ra, wd, ea, et);
            d_wr_req = 1'b0;
            @(negedge clk);
            chk("both_issued", {m_rd_req, m_wr_req}, 2'b11);
            wr_check_busy();
            tick();
            m_wr_rdy = 1'b1;
            @(negedge clk);
            wr_check_busy();
            tick();
            m_wr_rdy = 1'b0;
            @(negedge clk);
            chk("conc_drained", {m_wr_req, d_wr_rdy, m_rd_req}, 3'b011);
            tick();
            addr_phase(ea, et, 0);
            data_phase(wd, 4, 4);
        end

        // Reset after the second of four beats, with a write also in flight.
        grant(1, 0, $urandom(), 32'h0, wd, ea, et);
        wr_drive($urandom());
        tick();
        d_wr_req = 1'b0;
        addr_phase(ea, et, 1);
        data_phase(wd, 4, 2);
        m_ret_valid = 1'b1; m_ret_last = 1'b0; m_ret_data = $urandom();
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_outs", outs_any(), 0);
        chk("abort_wr_rdy", d_wr_rdy, 1);
        tick();
        resetn = 1'b1;
        last_d = 1'b0;
        @(negedge clk);
        chk("after_abort_outs", outs_any(), 0);
        chk("after_abort_wr_rdy", d_wr_rdy, 1);
        tick();
        m_ret_valid = 1'b0;
        do_read(1, 1, $urandom(), $urandom(), 1, 4);
        do_read(last_d, !last_d, $urandom(), $urandom(), 0, 4);

        // Random read traffic.
        for (int k = 0; k < 12; k++) begin
            int m;
            m = $urandom_range(1, 3);
            do_read(m[0], m[1], $urandom(), $urandom(), $urandom_range(0, 3),
                    $urandom_range(1, 4));
        end
        {i_rd_req, d_rd_req} = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL: i_rd_req, i_rd_type[2:0], i_rd_addr[31:0]  input  1/3/32  icache read request, type, line address.
REQ-004 SHALL: i_rd_rdy  output  1  icache read request accepted.
REQ-005 SHALL: i_ret_valid, i_ret_last, i_ret_data[31:0]  output  1/1/32  icache refill beat, last beat, data.
REQ-006 SHALL: d_rd_req, d_rd_type[2:0], d_rd_addr[31:0]  input  1/3/32  dcache read request.
REQ-007 SHALL: d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data[31:0]  output  1/1/1/32  dcache read accept and refill beat.
REQ-008 SHALL: d_wr_req, d_wr_type[2:0], d_wr_addr[31:0], d_wr_wstrb[3:0], d_wr_data[127:0]  input  dcache writeback request.
REQ-009 SHALL: d_wr_rdy  output  1  write buffer empty and able to accept.
REQ-010 SHALL: m_rd_req, m_rd_type[2:0], m_rd_addr[31:0]  output  memory-side read request.
REQ-011 SHALL: m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data[31:0]  input  memory-side read accept and return beats.
REQ-012 SHALL: m_wr_req, m_wr_type[2:0], m_wr_addr[31:0], m_wr_wstrb[3:0], m_wr_data[127:0]  output  memory-side write; m_wr_rdy  input  1  write accepted.

Function
REQ-013 SHALL: read FSM states R_IDLE, R_REQ, R_DATA; one read outstanding at a time.
REQ-014 SHALL: R_IDLE with any rd_req: pick winner, latch its type/addr and grant id, pulse winner's rd_rdy for that cycle, go R_REQ; loser's rd_rdy stays 0 and its request remains pending.
REQ-015 SHALL: R_REQ: m_rd_req=1 with latched type/addr unless read-after-write conflict (REQ-020); on m_rd_req & m_rd_rdy go R_DATA.
REQ-016 SHALL: R_DATA: m_ret_valid/m_ret_last/m_ret_data routed combinationally (0-cycle) to granted requester only; other requester sees ret_valid=0, ret_last=0; on m_ret_valid & m_ret_last go R_IDLE.
REQ-017 SHALL: new grant earliest the cycle after the last beat; no back-to-back grant in the same cycle as ret_last.
REQ-018 SHALL: write FSM states W_IDLE, W_BUSY; d_wr_rdy = (state==W_IDLE).
REQ-019 SHALL: W_IDLE with d_wr_req: latch type/addr/wstrb/data into buffer, go W_BUSY; W_BUSY: m_wr_req=1 from buffer until m_wr_rdy, then W_IDLE (m_wr_req deasserts next cycle).
REQ-020 SHALL: conflict = W_BUSY & (latched rd addr[31:4] == buffer addr[31:4]); while conflict m_rd_req=0; read issues the cycle after buffer drains.
REQ-021 SHALL: read and write channels operate concurrently when no conflict; simultaneous d_rd_req and d_wr_req both accepted same cycle.
REQ-022 SHALL: m_ret_valid outside R_DATA is ignored and routed to no requester.

Reset
REQ-023 SHALL: on resetn=0: read FSM R_IDLE, write FSM W_IDLE, buffers and latched addr cleared, round-robin pointer = icache.
REQ-024 SHALL: during/after reset all outputs 0 except d_wr_rdy=1; reset mid-transfer abandons it without further ret beats to either requester.

Configuration
REQ-025 SHALL: macro ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted last; pointer updates on each grant; after reset first tie goes to dcache.
REQ-026 SHALL: ARB_RR_EN undefined: fixed priority, dcache always wins ties; no pointer state.

Verification
REQ-027 SHALL: icache alone reads 0x1C000000, m_rd_rdy after 2 cycles, 4 beats -> i_rd_rdy 1-cycle pulse, m_rd_addr=0x1C000000, 4 i_ret_valid beats, i_ret_last on 4th, d_ret_valid never 1.
REQ-028 SHALL: i_rd_req and d_rd_req same cycle from reset -> dcache granted first; with ARB_RR_EN a following tie grants icache, without it dcache again.
REQ-029 SHALL: dcache write 0x00001230 pending (m_wr_rdy held 0 for 5 cycles) then dcache read 0x00001238 -> m_rd_req stays 0 until cycle after m_wr_rdy, then asserts.
REQ-030 SHALL: write to 0x00002000 and icache read 0x00003000 concurrent -> m_wr_req and m_rd_req both 1 same cycle; d_wr_rdy=0 until m_wr_rdy.
REQ-031 SHALL: resetn=0 after 2nd of 4 beats -> next cycle all outputs 0, d_wr_rdy=1; subsequent read completes normally.
REQ-032 SHALL: stray m_ret_valid=1 in R_IDLE -> i_ret_valid=d_ret_valid=0, FSM stays R_IDLE.
